// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: hit/miss sequencing, tree-PLRU replacement,
// dirty writeback, whole-cache flush and saturating performance counters.
module cache_control_nway #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 16,
  parameter int CNT_W    = 32,
  localparam int SW = $clog2(NUM_SETS),
  localparam int WW = $clog2(NUM_WAYS),
  localparam int PW = NUM_WAYS - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-1:0] dirty_vec,
  input  logic [PW-1:0]       plru_in,
  output logic [PW-1:0]       plru_out,
  output logic                load_plru,
  output logic [NUM_WAYS-1:0] way_sel,
  output logic                load_tag,
  output logic                load_valid,
  output logic                load_dirty,
  output logic                dirty_in,
  output logic                write_byte,
  output logic                write_all,
  output logic [1:0]          addr_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  input  logic                flush_req,
  output logic                flush_done,
  output logic [SW-1:0]       flush_set,
  output logic [CNT_W-1:0]    num_access,
  output logic [CNT_W-1:0]    num_misses,
  output logic [CNT_W-1:0]    num_writebacks
);

  typedef enum logic [2:0] {CHECK, WB, FILL, FL_SCAN, FL_WB} state_t;

  state_t              state, state_next;
  logic [WW-1:0]       victim, victim_next;
  logic [WW-1:0]       miss_victim, plru_victim, hit_idx, flush_way;
  logic [NUM_WAYS-1:0] victim_oh;
  logic [PW-1:0]       plru_upd;
  logic                req_valid, victim_dirty;
  logic                fs_clear, fs_inc, inc_miss, inc_wb;

  assign req_valid    = mem_read ^ mem_write;
  assign victim_oh    = NUM_WAYS'(1) << victim;
  assign victim_dirty = valid_vec[miss_victim] & dirty_vec[miss_victim];

  // Descending scans so the lowest-index candidate is the last one written.
  always_comb begin
    hit_idx     = '0;
    flush_way   = '0;
    miss_victim = plru_victim;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = WW'(i);
      if (valid_vec[i] & dirty_vec[i]) flush_way = WW'(i);
      if (!valid_vec[i]) miss_victim = WW'(i);
    end
  end

  always_comb begin
    int node;
    logic [PW-1:0] bits;
    node = 0;
    bits = '0;
    for (int l = 0; l < WW; l++) begin
      bits = plru_in >> node;
      node = 2 * node + 1 + int'(bits[0]);
    end
    plru_victim = WW'(node - PW);
  end

  // Each node on the accessed way's path is pointed at the opposite half.
  always_comb begin
    int node;
    logic [WW-1:0] wsh;
    logic dir;
    plru_upd = plru_in;
    node     = 0;
    wsh      = '0;
    dir      = 1'b0;
    for (int l = 0; l < WW; l++) begin
      wsh = hit_idx >> (WW - 1 - l);
      dir = wsh[0];
      if (dir) plru_upd = plru_upd & ~(PW'(1) << node);
      else     plru_upd = plru_upd | (PW'(1) << node);
      node = 2 * node + 1 + int'(dir);
    end
  end

  always_comb begin
    state_next  = state;
    victim_next = victim;
    fs_clear    = 1'b0;
    fs_inc      = 1'b0;
    inc_miss    = 1'b0;
    inc_wb      = 1'b0;
    mem_resp    = 1'b0;
    load_plru   = 1'b0;
    plru_out    = '0;
    way_sel     = '0;
    load_tag    = 1'b0;
    load_valid  = 1'b0;
    load_dirty  = 1'b0;
    dirty_in    = 1'b0;
    write_byte  = 1'b0;
    write_all   = 1'b0;
    addr_sel    = 2'd0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    flush_done  = 1'b0;
    if (rst) begin
      unique case (state)
        CHECK: begin
          if (req_valid) begin
            if (|hit_vec) begin
              mem_resp  = 1'b1;
              way_sel   = hit_vec;
              load_plru = 1'b1;
              plru_out  = plru_upd;
              if (mem_write) begin
                write_byte = 1'b1;
                load_dirty = 1'b1;
                dirty_in   = 1'b1;
              end
            end else begin
              victim_next = miss_victim;
              inc_miss    = 1'b1;
              state_next  = victim_dirty ? WB : FILL;
            end
          end else if (flush_req) begin
            fs_clear   = 1'b1;
            state_next = FL_SCAN;
          end
        end
        WB: begin
          pmem_write = 1'b1;
          addr_sel   = 2'd2;
          way_sel    = victim_oh;
          if (pmem_resp) begin
            load_dirty = 1'b1;
            inc_wb     = 1'b1;
            state_next = FILL;
          end
        end
        FILL: begin
          pmem_read  = 1'b1;
          addr_sel   = 2'd1;
          way_sel    = victim_oh;
          write_all  = 1'b1;
          load_tag   = 1'b1;
          load_valid = 1'b1;
          load_dirty = 1'b1;
          if (pmem_resp) state_next = CHECK;
        end
        FL_SCAN: begin
          addr_sel = 2'd3;
          if (|(valid_vec & dirty_vec)) begin
            victim_next = flush_way;
            state_next  = FL_WB;
          end else if (flush_set == SW'(NUM_SETS - 1)) begin
            flush_done = 1'b1;
            state_next = CHECK;
          end else begin
            fs_inc = 1'b1;
          end
        end
        FL_WB: begin
          pmem_write = 1'b1;
          addr_sel   = 2'd3;
          way_sel    = victim_oh;
          if (pmem_resp) begin
            load_dirty = 1'b1;
            inc_wb     = 1'b1;
            state_next = FL_SCAN;
          end
        end
        default: state_next = CHECK;
      endcase
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= CHECK;
      victim         <= '0;
      flush_set      <= '0;
      num_access     <= '0;
      num_misses     <= '0;
      num_writebacks <= '0;
    end else begin
      state  <= state_next;
      victim <= victim_next;
      if (fs_clear)    flush_set <= '0;
      else if (fs_inc) flush_set <= flush_set + 1'b1;
      if (mem_resp && num_access != '1)   num_access     <= num_access + 1'b1;
      if (inc_miss && num_misses != '1)   num_misses     <= num_misses + 1'b1;
      if (inc_wb && num_writebacks != '1) num_writebacks <= num_writebacks + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed-vector bench for cache_control_nway (4 ways, 16 sets): hits, clean/dirty
// misses, flush with a small dirty-bit array model, and reset mid-transaction.
module tb_cache_control_nway;
  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 16;
  localparam int CNT_W    = 32;

  logic        clk, rst;
  logic        mem_read, mem_write, mem_resp;
  logic [3:0]  hit_vec, valid_vec, dirty_vec;
  logic [2:0]  plru_in, plru_out;
  logic        load_plru;
  logic [3:0]  way_sel;
  logic        load_tag, load_valid, load_dirty, dirty_in, write_byte, write_all;
  logic [1:0]  addr_sel;
  logic        pmem_read, pmem_write, pmem_resp;
  logic        flush_req, flush_done;
  logic [3:0]  flush_set;
  logic [31:0] num_access, num_misses, num_writebacks;

  int         vector_count = 0;
  int         miscompares  = 0;
  logic [3:0] dirty_mem [16];
  int         write_count, done_count, done_set, resp_during_flush;
  int         write_set [2];
  logic [3:0] write_way [2];

  cache_control_nway #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .plru_in(plru_in), .plru_out(plru_out), .load_plru(load_plru), .way_sel(way_sel),
    .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty), .dirty_in(dirty_in),
    .write_byte(write_byte), .write_all(write_all), .addr_sel(addr_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .flush_req(flush_req), .flush_done(flush_done), .flush_set(flush_set),
    .num_access(num_access), .num_misses(num_misses), .num_writebacks(num_writebacks)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] hit,
                               input logic [3:0] valid, input logic [3:0] dirty,
                               input logic [2:0] plru, input logic presp, input logic flush);
    mem_read  = rd;
    mem_write = wr;
    hit_vec   = hit;
    valid_vec = valid;
    dirty_vec = dirty;
    plru_in   = plru;
    pmem_resp = presp;
    flush_req = flush;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_mem_resp", 32'(mem_resp), 0);
    checkOutput("rst_way_sel", 32'(way_sel), 0);
    checkOutput("rst_load_plru", 32'(load_plru), 0);
    checkOutput("rst_flush_set", 32'(flush_set), 0);
    checkOutput("rst_num_access", num_access, 0);

    // Read hit on way2, then write hit on way0.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rd_hit_resp", 32'(mem_resp), 1);
    checkOutput("rd_hit_way", 32'(way_sel), 'h4);
    checkOutput("rd_hit_plru", 32'(plru_out), 'h4);
    checkOutput("rd_hit_load_plru", 32'(load_plru), 1);
    checkOutput("rd_hit_write_byte", 32'(write_byte), 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0);
    #1;
    checkOutput("num_access_1", num_access, 1);
    checkOutput("wr_hit_resp", 32'(mem_resp), 1);
    checkOutput("wr_hit_plru", 32'(plru_out), 'h3);
    checkOutput("wr_hit_write_byte", 32'(write_byte), 1);
    checkOutput("wr_hit_dirty_in", 32'(dirty_in), 1);
    checkOutput("wr_hit_load_dirty", 32'(load_dirty), 1);

    // Read and write together is not a request.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'b0100, 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0);
    #1;
    checkOutput("both_resp", 32'(mem_resp), 0);
    checkOutput("num_access_2", num_access, 2);
    @(negedge clk);
    #1;
    checkOutput("both_resp_held", 32'(mem_resp), 0);
    checkOutput("both_no_count", num_access, 2);

    // Read miss, all valid and dirty, PLRU picks way1.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 3'b010, 1'b0, 1'b0);
    #1;
    checkOutput("miss_resp", 32'(mem_resp), 0);
    checkOutput("miss_no_pmem", 32'(pmem_write), 0);
    @(negedge clk);
    #1;
    checkOutput("wb_pmem_write", 32'(pmem_write), 1);
    checkOutput("wb_pmem_read", 32'(pmem_read), 0);
    checkOutput("wb_addr_sel", 32'(addr_sel), 2);
    checkOutput("wb_way", 32'(way_sel), 'h2);
    checkOutput("num_misses_1", num_misses, 1);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checkOutput("wb_resp_pmem_write", 32'(pmem_write), 1);
    checkOutput("wb_resp_load_dirty", 32'(load_dirty), 1);
    checkOutput("wb_resp_dirty_in", 32'(dirty_in), 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    checkOutput("fill_pmem_read", 32'(pmem_read), 1);
    checkOutput("fill_pmem_write", 32'(pmem_write), 0);
    checkOutput("fill_addr_sel", 32'(addr_sel), 1);
    checkOutput("fill_way", 32'(way_sel), 'h2);
    checkOutput("fill_write_all", 32'(write_all), 1);
    checkOutput("fill_load_valid", 32'(load_valid), 1);
    checkOutput("num_writebacks_1", num_writebacks, 1);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checkOutput("fill_hold_read", 32'(pmem_read), 1);
    @(negedge clk);
    pmem_resp = 1'b0;
    hit_vec   = 4'b0010;
    #1;
    checkOutput("retry_resp", 32'(mem_resp), 1);
    checkOutput("retry_way", 32'(way_sel), 'h2);
    checkOutput("retry_plru", 32'(plru_out), 'h1);

    // Write miss into invalid way2: no writeback.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1011, 4'b0000, 3'b000, 1'b0, 1'b0);
    #1;
    checkOutput("wmiss_resp", 32'(mem_resp), 0);
    checkOutput("num_access_3", num_access, 3);
    @(negedge clk);
    #1;
    checkOutput("wmiss_fill_read", 32'(pmem_read), 1);
    checkOutput("wmiss_no_write", 32'(pmem_write), 0);
    checkOutput("wmiss_way", 32'(way_sel), 'h4);
    checkOutput("wmiss_load_dirty", 32'(load_dirty), 1);
    checkOutput("wmiss_dirty_in", 32'(dirty_in), 0);
    checkOutput("num_misses_2", num_misses, 2);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    hit_vec   = 4'b0100;
    valid_vec = 4'b1111;
    #1;
    checkOutput("wretry_resp", 32'(mem_resp), 1);
    checkOutput("wretry_write_byte", 32'(write_byte), 1);
    checkOutput("wretry_dirty_in", 32'(dirty_in), 1);
    checkOutput("wmiss_no_wb", num_writebacks, 1);

    // Flush: only set 5 way3 and set 15 way0 are dirty.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b1);
    #1;
    checkOutput("flush_accept_resp", 32'(mem_resp), 0);
    for (int s = 0; s < 16; s++) dirty_mem[s] = 4'b0000;
    dirty_mem[5]      = 4'b1000;
    dirty_mem[15]     = 4'b0001;
    write_count       = 0;
    done_count        = 0;
    done_set          = -1;
    resp_during_flush = 0;
    write_set[0] = -1; write_set[1] = -1;
    write_way[0] = '0; write_way[1] = '0;
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    checkOutput("flush_set_start", 32'(flush_set), 0);
    for (int cyc = 0; cyc < 100 && done_count == 0; cyc++) begin
      mem_read  = 1'b1;
      hit_vec   = 4'b0001;
      valid_vec = 4'b1111;
      dirty_vec = dirty_mem[flush_set];
      pmem_resp = pmem_write;
      #1;
      if (mem_resp) resp_during_flush++;
      if (pmem_write && pmem_resp) begin
        if (write_count < 2) begin
          write_set[write_count] = int'(flush_set);
          write_way[write_count] = way_sel;
        end
        write_count++;
        dirty_mem[flush_set] = dirty_mem[flush_set] & ~way_sel;
      end
      if (flush_done) begin
        done_count++;
        done_set = int'(flush_set);
      end
      if (done_count == 0) @(negedge clk);
    end
    pmem_resp = 1'b0;
    checkOutput("flush_done_seen", done_count, 1);
    checkOutput("flush_done_set", done_set, 15);
    checkOutput("flush_write_count", write_count, 2);
    checkOutput("flush_wb0_set", write_set[0], 5);
    checkOutput("flush_wb0_way", 32'(write_way[0]), 'h8);
    checkOutput("flush_wb1_set", write_set[1], 15);
    checkOutput("flush_wb1_way", 32'(write_way[1]), 'h1);
    checkOutput("flush_cpu_blocked", resp_during_flush, 0);
    @(negedge clk);
    #1;
    checkOutput("flush_done_pulse", 32'(flush_done), 0);
    checkOutput("post_flush_resp", 32'(mem_resp), 1);
    checkOutput("num_writebacks_3", num_writebacks, 3);

    // Reset asserted in the middle of a fill.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0);
    #1;
    checkOutput("rfill_miss_resp", 32'(mem_resp), 0);
    @(negedge clk);
    #1;
    checkOutput("rfill_pmem_read", 32'(pmem_read), 1);
    checkOutput("rfill_way", 32'(way_sel), 'h8);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_fill_pmem_read", 32'(pmem_read), 0);
    checkOutput("rst_fill_way", 32'(way_sel), 0);
    checkOutput("rst_fill_write_all", 32'(write_all), 0);
    checkOutput("rst_num_misses", num_misses, 0);
    checkOutput("rst_num_writebacks", num_writebacks, 0);
    @(negedge clk);
    rst       = 1'b1;
    hit_vec   = 4'b0001;
    valid_vec = 4'b1111;
    #1;
    checkOutput("post_rst_resp", 32'(mem_resp), 1);
    checkOutput("post_rst_pmem_read", 32'(pmem_read), 0);
    @(negedge clk);
    mem_write = 1'b1;
    #1;
    checkOutput("post_rst_both_resp", 32'(mem_resp), 0);
    @(negedge clk);
    #1;
    checkOutput("post_rst_num_access", num_access, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 NUM_WAYS, 4, associativity; power of two, 2..8.
REQ-002 NUM_SETS, 16, sets; power of two, 2..256; SW = log2(NUM_SETS).
REQ-003 CNT_W, 32, performance counter width.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 mem_read, mem_write  in  1 each  CPU request; held until mem_resp.
REQ-007 mem_resp  out  1  request complete.
REQ-008 hit_vec, valid_vec, dirty_vec  in  NUM_WAYS each  per-way status of the addressed set.
REQ-009 plru_in  in  NUM_WAYS-1  tree-PLRU bits of the addressed set; plru_out  out  NUM_WAYS-1  updated bits; load_plru  out  1.
REQ-010 way_sel  out  NUM_WAYS  one-hot way targeted by all load/write strobes.
REQ-011 load_tag, load_valid, load_dirty, dirty_in, write_byte, write_all  out  1 each  array strobes applied to way_sel.
REQ-012 addr_sel  out  2  0=CPU, 1=fill (CPU tag), 2=writeback (victim tag), 3=flush (flush_set, victim tag).
REQ-013 pmem_read, pmem_write  out  1; pmem_resp  in  1.
REQ-014 flush_req  in  1; flush_done  out  1; flush_set  out  SW.
REQ-015 num_access, num_misses, num_writebacks  out  CNT_W each.

Function
REQ-016 States: CHECK, WB, FILL, FL_SCAN, FL_WB; all strobes default 0, addr_sel 0.
REQ-017 Valid request = mem_read XOR mem_write; both high is no request, never acknowledged.
REQ-018 CHECK, valid request, hit: mem_resp=1 same cycle; way_sel=hit_vec; load_plru=1; write additionally asserts write_byte, load_dirty, dirty_in=1.
REQ-019 CHECK, valid request, miss: latch victim; dirty victim -> WB, else -> FILL; num_misses +1.
REQ-020 Victim = lowest-index way with valid_vec=0; if all valid, the way indicated by plru_in.
REQ-021 PLRU tree: bit0 root, node i children 2i+1/2i+2, leaves in way order; node bit 1 = victim in upper half; an access sets every node on the accessed way's path to point away from it, other bits unchanged.
REQ-022 WB: pmem_write=1, addr_sel=2, way_sel=victim; on pmem_resp: load_dirty=1, dirty_in=0, num_writebacks +1, -> FILL.
REQ-023 FILL: pmem_read=1, addr_sel=1, way_sel=victim, write_all=load_tag=load_valid=1, load_dirty=1, dirty_in=0; on pmem_resp -> CHECK; the retried request then hits.
REQ-024 Miss latency: clean = pmem FILL latency + 1 cycle; dirty = WB + FILL + 1.
REQ-025 Flush accepted only in CHECK with no valid request; flush_set cleared -> FL_SCAN.
REQ-026 FL_SCAN (addr_sel=3): if any valid&dirty way, latch lowest-index one -> FL_WB; else if flush_set=NUM_SETS-1, flush_done=1 for one cycle -> CHECK; else flush_set +1.
REQ-027 FL_WB: pmem_write=1, addr_sel=3, way_sel=latched way; on pmem_resp clear that dirty bit, num_writebacks +1 -> FL_SCAN (same set rescanned).
REQ-028 CPU requests during flush: mem_resp held 0 until return to CHECK.
REQ-029 num_access +1 each cycle mem_resp=1; all counters saturate at all-ones, no wrap.
REQ-030 Victim, way_sel and addr_sel stay constant for the whole WB/FILL/FL_WB transaction; pmem_read and pmem_write are never both 1.
REQ-031 Request dropped mid-miss: transaction still completes before returning to CHECK.

Reset
REQ-032 rst low asynchronously forces CHECK, flush_set=0, victim=0, counters=0; all outputs 0 while low.
REQ-033 Reset mid-WB/FILL abandons the transaction; pmem_read/pmem_write drop immediately.

Verification (NUM_WAYS=4, NUM_SETS=16)
REQ-034 Read, hit_vec=0100, plru_in=000 -> mem_resp same cycle, way_sel=0100, plru_out=100, num_access=1.
REQ-035 Read miss, all valid, dirty_vec=1111, plru_in=010 -> victim way1: WB, FILL, CHECK; num_misses=1, num_writebacks=1.
REQ-036 Write miss, valid_vec=1011 -> victim way2, no WB; FILL load_dirty with dirty_in=0; retry writes with dirty_in=1.
REQ-037 Flush, only set 5 way3 and set 15 way0 dirty -> exactly two pmem writes, flush_done one cycle after set 15 scan, num_writebacks=2.
REQ-038 rst low during FILL -> pmem_read=0 immediately; CHECK after release; mem_read and mem_write both high -> no mem_resp.
